// File: rtl/trace_stream_serializer.sv
// trace_stream_serializer
// Takes one wide trace packet per input handshake, holds it, and replays it as
// IN_WIDTH/OUT_WIDTH narrow beats, most-significant chunk first. Packet tlast
// appears only on the final beat. Three wrap-around counters track input
// packets, output beats and completed transfers for software.
module trace_stream_serializer #(
  parameter int IN_WIDTH  = 1024,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic [31:0]          packets_in,
  output logic [31:0]          beats_out,
  output logic [31:0]          transfers_out
);

  localparam int N_BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);

  // Reject widths that do not split into at least two whole beats.
  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || N_BEATS < 2) begin : gBadParams
      $error("trace_stream_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                             state_q;
  logic [BW-1:0]                      beat_q;
  logic [N_BEATS-1:0][OUT_WIDTH-1:0]  held_q;
  logic                               held_last_q;
  logic [31:0]                        packets_in_q;
  logic [31:0]                        beats_out_q;
  logic [31:0]                        transfers_out_q;

  logic onLastBeat;
  logic inHs;
  logic outHs;

  // Handshake decode; the only M_AXIS_tready to S_AXIS_tready path is the
  // final-beat reload that lets packets run back-to-back without a bubble.
  assign onLastBeat    = (beat_q == LAST_BEAT);
  assign S_AXIS_tready = ~rst & en &
                         ((state_q == IDLE) |
                          ((state_q == SEND) & onLastBeat & M_AXIS_tready));
  assign inHs          = S_AXIS_tvalid & S_AXIS_tready;
  assign outHs         = M_AXIS_tvalid & M_AXIS_tready;

  // Output beat selection from held registers; chunk N_BEATS-1 is the MS chunk
  // and goes out first, so beat b reads chunk N_BEATS-1-b.
  assign M_AXIS_tvalid = (state_q == SEND);
  assign M_AXIS_tdata  = held_q[LAST_BEAT - beat_q];
  assign M_AXIS_tlast  = held_last_q & onLastBeat;

  assign packets_in    = packets_in_q;
  assign beats_out     = beats_out_q;
  assign transfers_out = transfers_out_q;

  // Serializer FSM, held packet and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      held_q          <= '0;
      held_last_q     <= 1'b0;
      packets_in_q    <= '0;
      beats_out_q     <= '0;
      transfers_out_q <= '0;
    end else begin
      if (inHs) begin
        packets_in_q <= packets_in_q + 32'd1;
      end
      if (outHs) begin
        beats_out_q <= beats_out_q + 32'd1;
        if (M_AXIS_tlast) begin
          transfers_out_q <= transfers_out_q + 32'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (inHs) begin
            held_q      <= S_AXIS_tdata;
            held_last_q <= S_AXIS_tlast;
            beat_q      <= '0;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (outHs) begin
            if (!onLastBeat) begin
              beat_q <= beat_q + BW'(1);
            end else if (inHs) begin
              held_q      <= S_AXIS_tdata;
              held_last_q <= S_AXIS_tlast;
              beat_q      <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_stream_serializer.sv
// tb_trace_stream_serializer
// Directed bench for trace_stream_serializer at IN_WIDTH=256, OUT_WIDTH=64.
// A vector table covers single-packet and back-to-back traffic cycle by cycle;
// hand-written sequences cover backpressure, en gating, mid-packet reset and
// counter wrap.
module tb_trace_stream_serializer;

  localparam int IW = 256;
  localparam int OW = 64;

  localparam logic [IW-1:0] P1 = {64'h4, 64'h3, 64'h2, 64'h1};
  localparam logic [IW-1:0] PA = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
  localparam logic [IW-1:0] PB = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
  localparam logic [IW-1:0] PC = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
  localparam logic [IW-1:0] PD = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
  localparam logic [IW-1:0] PE = {64'hE3, 64'hE2, 64'hE1, 64'hE0};

  logic          clk;
  logic          rst;
  logic          en;
  logic          sValid;
  logic          sReady;
  logic [IW-1:0] sData;
  logic          sLast;
  logic          mValid;
  logic          mReady;
  logic [OW-1:0] mData;
  logic          mLast;
  logic [31:0]   packetsIn;
  logic [31:0]   beatsOut;
  logic [31:0]   transfersOut;

  int checks;
  int errors;

  typedef struct packed {
    logic          rst;
    logic          en;
    logic          sv;
    logic [IW-1:0] sd;
    logic          sl;
    logic          mr;
    logic          expSr;
    logic          expMv;
    logic [OW-1:0] expMd;
    logic          expMl;
    logic          chkCnt;
    logic [31:0]   expPk;
    logic [31:0]   expBo;
    logic [31:0]   expTr;
  } vec_t;

  vec_t vecs [21];

  trace_stream_serializer #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .S_AXIS_tvalid(sValid),
    .S_AXIS_tready(sReady),
    .S_AXIS_tdata (sData),
    .S_AXIS_tlast (sLast),
    .M_AXIS_tvalid(mValid),
    .M_AXIS_tready(mReady),
    .M_AXIS_tdata (mData),
    .M_AXIS_tlast (mLast),
    .packets_in   (packetsIn),
    .beats_out    (beatsOut),
    .transfers_out(transfersOut)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic sv,
                              input logic [IW-1:0] sd, input logic sl, input logic mr,
                              input logic expSr, input logic expMv,
                              input logic [OW-1:0] expMd, input logic expMl,
                              input logic chkCnt, input logic [31:0] pk,
                              input logic [31:0] bo, input logic [31:0] tr);
    vec_t v;
    v.rst = r;  v.en = e;  v.sv = sv;  v.sd = sd;  v.sl = sl;  v.mr = mr;
    v.expSr = expSr;  v.expMv = expMv;  v.expMd = expMd;  v.expMl = expMl;
    v.chkCnt = chkCnt;  v.expPk = pk;  v.expBo = bo;  v.expTr = tr;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst    = v.rst;
    en     = v.en;
    sValid = v.sv;
    sData  = v.sd;
    sLast  = v.sl;
    mReady = v.mr;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " s_tready"}, 64'(sReady), 64'(v.expSr));
    checkVal({tag, " m_tvalid"}, 64'(mValid), 64'(v.expMv));
    if (v.expMv) begin
      checkVal({tag, " m_tdata"}, mData, v.expMd);
      checkVal({tag, " m_tlast"}, 64'(mLast), 64'(v.expMl));
    end
    if (v.chkCnt) begin
      checkVal({tag, " packets_in"}, 64'(packetsIn), 64'(v.expPk));
      checkVal({tag, " beats_out"}, 64'(beatsOut), 64'(v.expBo));
      checkVal({tag, " transfers_out"}, 64'(transfersOut), 64'(v.expTr));
    end
  endtask

  // Called at a falling edge: drive, let combinational outputs settle, check,
  // then advance to the next falling edge (the rising edge happens in between).
  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    #1;
    checkOutput(tag, v);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic sv,
                      input logic [IW-1:0] sd, input logic sl, input logic mr,
                      input logic expSr, input logic expMv,
                      input logic [OW-1:0] expMd, input logic expMl);
    runVec(tag, mk(r, e, sv, sd, sl, mr, expSr, expMv, expMd, expMl, 1'b0, 0, 0, 0));
  endtask

  task automatic resetDut();
    applyStimulus(mk(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0, 0));
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Single packet, then reset, then three back-to-back packets.
    vecs[0]  = mk(0,1,1,P1,1,1, 1,0,64'h0,0, 1, 0,0,0);
    vecs[1]  = mk(0,1,0,'0,0,1, 0,1,64'h4,0, 1, 1,0,0);
    vecs[2]  = mk(0,1,0,'0,0,1, 0,1,64'h3,0, 1, 1,1,0);
    vecs[3]  = mk(0,1,0,'0,0,1, 0,1,64'h2,0, 1, 1,2,0);
    vecs[4]  = mk(0,1,0,'0,0,1, 1,1,64'h1,1, 1, 1,3,0);
    vecs[5]  = mk(0,1,0,'0,0,1, 1,0,64'h0,0, 1, 1,4,1);
    vecs[6]  = mk(1,1,0,'0,0,1, 0,0,64'h0,0, 1, 1,4,1);
    vecs[7]  = mk(0,1,1,PA,1,1, 1,0,64'h0,0, 1, 0,0,0);
    vecs[8]  = mk(0,1,1,PB,0,1, 0,1,64'hA3,0, 1, 1,0,0);
    vecs[9]  = mk(0,1,1,PB,0,1, 0,1,64'hA2,0, 1, 1,1,0);
    vecs[10] = mk(0,1,1,PB,0,1, 0,1,64'hA1,0, 1, 1,2,0);
    vecs[11] = mk(0,1,1,PB,0,1, 1,1,64'hA0,1, 1, 1,3,0);
    vecs[12] = mk(0,1,1,PC,1,1, 0,1,64'hB3,0, 1, 2,4,1);
    vecs[13] = mk(0,1,1,PC,1,1, 0,1,64'hB2,0, 1, 2,5,1);
    vecs[14] = mk(0,1,1,PC,1,1, 0,1,64'hB1,0, 1, 2,6,1);
    vecs[15] = mk(0,1,1,PC,1,1, 1,1,64'hB0,0, 1, 2,7,1);
    vecs[16] = mk(0,1,0,'0,0,1, 0,1,64'hC3,0, 1, 3,8,1);
    vecs[17] = mk(0,1,0,'0,0,1, 0,1,64'hC2,0, 1, 3,9,1);
    vecs[18] = mk(0,1,0,'0,0,1, 0,1,64'hC1,0, 1, 3,10,1);
    vecs[19] = mk(0,1,0,'0,0,1, 1,1,64'hC0,1, 1, 3,11,1);
    vecs[20] = mk(0,1,0,'0,0,1, 1,0,64'h0,0, 1, 3,12,2);

    // Reset state, checked while rst is still high.
    applyStimulus(mk(1'b1, 1'b1, 1'b1, P1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0, 0));
    @(negedge clk);
    #1;
    checkVal("reset s_tready", 64'(sReady), 64'h0);
    checkVal("reset m_tvalid", 64'(mValid), 64'h0);
    checkVal("reset m_tdata", mData, 64'h0);
    checkVal("reset m_tlast", 64'(mLast), 64'h0);
    checkVal("reset packets_in", 64'(packetsIn), 64'h0);
    checkVal("reset beats_out", 64'(beatsOut), 64'h0);
    checkVal("reset transfers_out", 64'(transfersOut), 64'h0);
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: a second packet waits until the final beat handshakes.
    resetDut();
    step("bp accept", 0,1,1,PD,1,1, 1,0,64'h0,0);
    begin
      logic          mrPat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [OW-1:0] expBeat[7] = '{64'hD3, 64'hD2, 64'hD2, 64'hD2, 64'hD1, 64'hD1, 64'hD0};
      for (int p = 0; p < 7; p++) begin
        step($sformatf("bp%0d", p), 0,1,1,PE,0,mrPat[p],
             (p == 6), 1, expBeat[p], (p == 6));
      end
    end
    step("bp e0", 0,1,0,'0,0,1, 0,1,64'hE3,0);
    step("bp e1", 0,1,0,'0,0,1, 0,1,64'hE2,0);
    step("bp e2", 0,1,0,'0,0,1, 0,1,64'hE1,0);
    step("bp e3", 0,1,0,'0,0,1, 1,1,64'hE0,0);
    step("bp idle", 0,1,0,'0,0,1, 1,0,64'h0,0);
    checkVal("bp packets_in", 64'(packetsIn), 64'd2);
    checkVal("bp beats_out", 64'(beatsOut), 64'd8);
    checkVal("bp transfers_out", 64'(transfersOut), 64'd1);

    // en dropped mid-packet: A drains, B waits until en returns.
    resetDut();
    step("en acceptA", 0,1,1,PA,1,1, 1,0,64'h0,0);
    step("en a0", 0,1,1,PB,1,1, 0,1,64'hA3,0);
    step("en a1", 0,0,1,PB,1,1, 0,1,64'hA2,0);
    step("en a2", 0,0,1,PB,1,1, 0,1,64'hA1,0);
    step("en a3", 0,0,1,PB,1,1, 0,1,64'hA0,1);
    step("en wait0", 0,0,1,PB,1,1, 0,0,64'h0,0);
    step("en wait1", 0,0,1,PB,1,1, 0,0,64'h0,0);
    step("en acceptB", 0,1,1,PB,1,1, 1,0,64'h0,0);
    step("en b0", 0,1,0,'0,0,1, 0,1,64'hB3,0);
    step("en b1", 0,1,0,'0,0,1, 0,1,64'hB2,0);
    step("en b2", 0,1,0,'0,0,1, 0,1,64'hB1,0);
    step("en b3", 0,1,0,'0,0,1, 1,1,64'hB0,1);
    checkVal("en packets_in", 64'(packetsIn), 64'd2);
    checkVal("en transfers_out", 64'(transfersOut), 64'd2);

    // Reset during beat 2 discards the packet and clears the counters.
    resetDut();
    step("rst accept", 0,1,1,P1,1,1, 1,0,64'h0,0);
    step("rst b0", 0,1,0,'0,0,1, 0,1,64'h4,0);
    step("rst b1", 0,1,0,'0,0,1, 0,1,64'h3,0);
    step("rst b2", 1,1,0,'0,0,1, 0,1,64'h2,0);
    step("rst after", 0,1,0,'0,0,1, 1,0,64'h0,0);
    checkVal("rst packets_in", 64'(packetsIn), 64'd0);
    checkVal("rst beats_out", 64'(beatsOut), 64'd0);
    checkVal("rst transfers_out", 64'(transfersOut), 64'd0);
    step("rst next", 0,1,1,PC,1,1, 1,0,64'h0,0);
    step("rst next b0", 0,1,0,'0,0,1, 0,1,64'hC3,0);
    checkVal("rst next packets_in", 64'(packetsIn), 64'd1);

    // beats_out wrap with a tlast=0 packet.
    resetDut();
    applyStimulus(mk(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0, 0));
    force dut.beats_out_q = 32'hFFFF_FFFE;
    #1;
    release dut.beats_out_q;
    #1;
    checkVal("wrap preload", 64'(beatsOut), 64'hFFFF_FFFE);
    @(negedge clk);
    step("wrap accept", 0,1,1,PA,0,1, 1,0,64'h0,0);
    step("wrap b0", 0,1,0,'0,0,1, 0,1,64'hA3,0);
    step("wrap b1", 0,1,0,'0,0,1, 0,1,64'hA2,0);
    step("wrap b2", 0,1,0,'0,0,1, 0,1,64'hA1,0);
    step("wrap b3", 0,1,0,'0,0,1, 1,1,64'hA0,0);
    checkVal("wrap beats_out", 64'(beatsOut), 64'd2);
    checkVal("wrap transfers_out", 64'(transfersOut), 64'd0);
    checkVal("wrap packets_in", 64'(packetsIn), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_stream_serializer.md
Name: trace_stream_serializer

Overview:
- Sits directly downstream of the continuous monitoring system's wide AXI-Stream master output and upstream of the 64-bit DMA/FIFO port.
- Accepts one wide trace packet per handshake, holds it, and emits it as IN_WIDTH/OUT_WIDTH narrow beats, most-significant chunk first.
- Propagates packet tlast onto the final beat only, and keeps wrap-around statistics counters readable by software.

Parameters:
- IN_WIDTH, 1024: width of the input trace packet. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64: width of each output beat.
- N_BEATS, IN_WIDTH/OUT_WIDTH (derived, localparam): beats per packet. Must be at least 2; elaboration error otherwise.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  when low, no new input packet is accepted; a packet already held still drains.
- S_AXIS_tvalid  input  1  input packet valid.
- S_AXIS_tready  output  1  input ready.
- S_AXIS_tdata  input  IN_WIDTH  input packet.
- S_AXIS_tlast  input  1  input packet ends a transfer.
- M_AXIS_tvalid  output  1  output beat valid.
- M_AXIS_tready  input  1  output ready.
- M_AXIS_tdata  output  OUT_WIDTH  output beat.
- M_AXIS_tlast  output  1  final beat of a tlast packet.
- packets_in  output  32  count of input handshakes; wraps.
- beats_out  output  32  count of output handshakes; wraps.
- transfers_out  output  32  count of output handshakes with tlast=1; wraps.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). Reset is sampled only on the clk rising edge.
- Reset values:
  - state=IDLE, beat index=0.
  - M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0.
  - Held word=0, held tlast=0.
  - All three counters=0.
  - S_AXIS_tready=0 while rst=1.
- States:
  - IDLE: nothing held.
  - SEND: a word is held and beat index b is in 0..N_BEATS-1.
- Outputs, all driven from registers only:
  - M_AXIS_tvalid = (state==SEND).
  - M_AXIS_tdata = held[IN_WIDTH-1-b*OUT_WIDTH -: OUT_WIDTH], so beat 0 is the MS chunk.
  - M_AXIS_tlast = held_tlast & (b==N_BEATS-1).
- Ready: S_AXIS_tready = ~rst & en & ((state==IDLE) | (state==SEND & b==N_BEATS-1 & M_AXIS_tready)). This is the only combinational path from M_AXIS_tready to S_AXIS_tready.
- Input handshake (S_AXIS_tvalid & S_AXIS_tready):
  - Capture tdata and tlast.
  - Set b=0 and state=SEND.
  - Increment packets_in.
- Output handshake (M_AXIS_tvalid & M_AXIS_tready):
  - Increment beats_out.
  - Also increment transfers_out if M_AXIS_tlast=1.
  - If b<N_BEATS-1: b<=b+1.
  - Else, with a simultaneous input handshake: reload the new word, b=0, stay in SEND (back-to-back, no bubble).
  - Else: go to IDLE.
- Stall: M_AXIS_tdata, M_AXIS_tlast and b hold stable while M_AXIS_tvalid=1 and M_AXIS_tready=0. Valid is never withdrawn without a handshake, except by rst.
- Latency: a packet accepted at edge k presents beat 0 in the cycle after k.
- Throughput: steady state is exactly N_BEATS cycles per packet, with 100% output utilisation when tready=1.
- en low mid-packet: the current packet finishes all N_BEATS beats, then the block sits in IDLE. en is not sampled for the output side.
- rst mid-packet: the held word is discarded; M_AXIS_tvalid=0 in the cycle after the rst edge. Counters clear.
- Counter wrap: 0xFFFFFFFF+1 = 0. All counters increment in the same cycle as their handshake, and each increments at most once per cycle.
- S_AXIS_tdata is ignored when no input handshake occurs.

Test Plan (IN_WIDTH=256, OUT_WIDTH=64, N_BEATS=4):
- Single packet:
  - Stimulus: reset, en=1, M_AXIS_tready=1, send 0x0000000000000004_0000000000000003_0000000000000002_0000000000000001 with tlast=1.
  - Response: beats 0x4, 0x3, 0x2, 0x1 on consecutive cycles starting the cycle after accept; tlast only on 0x1; packets_in=1, beats_out=4, transfers_out=1.
- Back-to-back:
  - Stimulus: S_AXIS_tvalid held 1 for 3 packets, tready=1.
  - Response: 12 contiguous valid beats with no gap; S_AXIS_tready high only in IDLE and on each final-beat cycle; beats_out=12.
- Backpressure:
  - Stimulus: toggle M_AXIS_tready 1,0,0,1,0,1,1.
  - Response: tdata/tlast stable during every stall; all 4 beats delivered in order; no input accepted until beat 3 handshakes.
- en gating:
  - Stimulus: drop en after beat 1 of packet A while packet B is pending.
  - Response: A completes all 4 beats; B is not accepted (S_AXIS_tready=0) until en=1; then B is emitted normally.
- Reset mid-packet:
  - Stimulus: assert rst during beat 2.
  - Response: M_AXIS_tvalid=0 the next cycle; counters=0; the next packet after rst release starts at its beat 0.
- Wrap and tlast=0:
  - Stimulus: preload beats_out to 0xFFFFFFFE via a force in the bench, send one tlast=0 packet.
  - Response: beats_out=2 after 4 beats; no beat has tlast; transfers_out is unchanged.
